mipi_tx_byte_framer: RTL and testbench

Transmit-side lane framer for the MIPI CSI bridge. Accepts packet bytes over a valid/ready handshake and emits one lane's byte stream in HS burst framing: LP entry sequence, HS-zero leader, sync byte 0xB8, payload, then HS-trail. Sits between the packet builder and the DDR TX serializer. Output bytes are LSB-first on the wire, so bit 7 is the last bit sent.

---
 rtl/mipi_tx_byte_framer.sv | 86 ++++++++
 tb/tb_mipi_tx_byte_framer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_tx_byte_framer.sv
// mipi_tx_byte_framer: HS burst lane framer (LP entry, HS-zero, 0xB8 sync, payload, trail); LP entry sequence under MIPI_TX_LP_SEQUENCE_EN
module mipi_tx_byte_framer #(
  parameter int ZERO_BYTES  = 4,
  parameter int TRAIL_BYTES = 2,
  parameter int LPX_CYCLES  = 3
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       byte_last_i,
  output logic       byte_ready_o,
  output logic [7:0] byte_o,
  output logic       hs_en_o,
  output logic [1:0] lp_o,
  output logic       busy_o,
  output logic       underflow_o
);
  typedef enum logic [2:0] {IDLE, LP_RQST, LP_BRIDGE, HS_ZERO, SYNC, DATA, TRAIL, EXIT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic trail_bit, trail_bit_nxt;
  logic xfer, done, underflow;
  assign byte_ready_o = (state == SYNC) || (state == DATA);
  assign xfer = byte_valid_i & byte_ready_o;
  assign done = xfer & byte_last_i;
  assign underflow = byte_ready_o & ~byte_valid_i;
  // next state, per-state counter load and trail polarity capture
  always_comb begin
    state_nxt = state;
    cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    trail_bit_nxt = done ? byte_i[7] : underflow ? byte_o[7] : trail_bit;
    case (state)
      IDLE: if (byte_valid_i) begin
`ifdef MIPI_TX_LP_SEQUENCE_EN
        state_nxt = LP_RQST;
        cnt_nxt = 4'(LPX_CYCLES - 1);
`else
        state_nxt = HS_ZERO;
        cnt_nxt = 4'(ZERO_BYTES - 1);
`endif
      end
`ifdef MIPI_TX_LP_SEQUENCE_EN
      LP_RQST: if (cnt == 4'd0) begin
        state_nxt = LP_BRIDGE;
        cnt_nxt = 4'(LPX_CYCLES - 1);
      end
      LP_BRIDGE: if (cnt == 4'd0) begin
        state_nxt = HS_ZERO;
        cnt_nxt = 4'(ZERO_BYTES - 1);
      end
`endif
      HS_ZERO: if (cnt == 4'd0) state_nxt = SYNC;
      // the last payload byte is still on the wire during the first TRAIL cycle, hence one extra count
      SYNC, DATA: begin
        state_nxt = (done || underflow) ? TRAIL : DATA;
        cnt_nxt = done ? 4'(TRAIL_BYTES) : underflow ? 4'(TRAIL_BYTES - 1) : 4'd0;
      end
      TRAIL: if (cnt == 4'd0) state_nxt = EXIT;
      EXIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, counter and registered lane outputs decoded from the next state
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      trail_bit <= 1'b0;
      byte_o <= 8'h00;
      hs_en_o <= 1'b0;
      lp_o <= 2'b11;
      busy_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      trail_bit <= trail_bit_nxt;
      byte_o <= xfer ? byte_i : (state_nxt == SYNC) ? 8'hB8 : (state_nxt == TRAIL) ? {8{~trail_bit_nxt}} : 8'h00;
      hs_en_o <= state_nxt inside {HS_ZERO, SYNC, DATA, TRAIL};
      lp_o <= (state_nxt == IDLE || state_nxt == EXIT) ? 2'b11 : (state_nxt == LP_RQST) ? 2'b01 : 2'b00;
      busy_o <= state_nxt != IDLE;
      underflow_o <= underflow;
    end
  end
endmodule

// File: tb/tb_mipi_tx_byte_framer.sv
// tb_mipi_tx_byte_framer: directed packets checked every cycle against a burst-level framing model
module tb_mipi_tx_byte_framer;
  localparam int Z = 4;
  localparam int T = 2;
  localparam int L = 3;
`ifdef MIPI_TX_LP_SEQUENCE_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif
  localparam int SYNC_IDX = LP_EN ? 1 + 2 * L + Z : 1 + Z;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic valid = 1'b0;
  logic last = 1'b0;
  logic ready;
  logic [7:0] byte_out;
  logic hs_en;
  logic [1:0] lp;
  logic busy;
  logic uf;

  mipi_tx_byte_framer #(.ZERO_BYTES(Z), .TRAIL_BYTES(T), .LPX_CYCLES(L)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .byte_i(byte_in), .byte_valid_i(valid),
    .byte_last_i(last), .byte_ready_o(ready), .byte_o(byte_out), .hs_en_o(hs_en),
    .lp_o(lp), .busy_o(busy), .underflow_o(uf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic hs;
    logic [1:0] lp;
    logic busy;
    logic uf;
    logic rdy;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] s_byte[$];
  logic s_last[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  function automatic void put(input logic [7:0] b, input logic hs, input logic [1:0] l,
                              input logic bz, input logic u, input logic r);
    exp_t e;
    e.b = b; e.hs = hs; e.lp = l; e.busy = bz; e.uf = u; e.rdy = r;
    exp_q.push_back(e);
  endfunction

  // Whole-burst view: each burst is IDLE, LP entry, leader, sync, payload, trail, exit.
  function automatic void model(input int gap);
    int k = 0;
    int acc = 0;
    logic tbit;
    logic under;
    while (k < s_byte.size()) begin
      put(8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
      if (LP_EN) begin
        for (int i = 0; i < L; i++) put(8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < L; i++) put(8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < Z; i++) put(8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
      put(8'hB8, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
      tbit = 1'b1;
      under = 1'b0;
      while (k < s_byte.size()) begin
        acc++;
        under = (acc == gap) && !s_last[k];
        put(s_byte[k], 1'b1, 2'b00, 1'b1, 1'b0, !s_last[k]);
        tbit = s_byte[k][7];
        k++;
        if (s_last[k-1] || under) break;
      end
      for (int i = 0; i < T; i++) put(tbit ? 8'h00 : 8'hFF, 1'b1, 2'b00, 1'b1, under && i == 0, 1'b0);
      put(8'h00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    end
  endfunction

  // single compare process: one model entry per cycle while a burst is expected
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("byte_o", byte_out, e.b);
      chk("hs_en_o", {7'd0, hs_en}, {7'd0, e.hs});
      chk("lp_o", {6'd0, lp}, {6'd0, e.lp});
      chk("busy_o", {7'd0, busy}, {7'd0, e.busy});
      chk("underflow_o", {7'd0, uf}, {7'd0, e.uf});
      chk("byte_ready_o", {7'd0, ready}, {7'd0, e.rdy});
    end
  end

  task automatic drive(input int gap, input int stop);
    int i = 0;
    int budget = 0;
    bit hold = 0;
    bit acc;
    valid = 1'b1;
    byte_in = s_byte[0];
    last = s_last[0];
    while (i < stop && budget < 500) begin
      @(negedge clk);
      acc = valid && ready;
      @(posedge clk);
      #1;
      budget++;
      if (hold) begin
        valid = 1'b1;
        hold = 0;
      end
      if (acc) begin
        i++;
        if (i < s_byte.size()) begin
          byte_in = s_byte[i];
          last = s_last[i];
        end else valid = 1'b0;
        if (i == gap && i < s_byte.size()) begin
          valid = 1'b0;
          hold = 1;
        end
      end
    end
    checks++;
    if (budget >= 500) begin
      errors++;
      $display("FAIL accept_timeout: accepted %0d, expected %0d", i, stop);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL burst_timeout: %0d model cycles left, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h;
    int u;
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int u;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_lp", {6'd0, lp}, 8'd3);
    chk("reset_hs", {7'd0, hs_en}, 8'd0);
    chk("reset_byte", byte_out, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_ready", {7'd0, ready}, 8'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    s_byte = '{8'h11, 8'h22, 8'h33, 8'h84};
    s_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    model(0);
    h = 0;
    foreach (exp_q[i]) if (exp_q[i].hs) h++;
    chk("pin_sync_pos", exp_q[SYNC_IDX].b, 8'hB8);
    chk("pin_first_lp", {6'd0, exp_q[1].lp}, LP_EN ? 8'd1 : 8'd0);
    chk("pin_hs_len", 8'(h), 8'd11);
    chk("pin_payload_last", exp_q[SYNC_IDX + 4].b, 8'h84);
    chk("pin_trail0", exp_q[SYNC_IDX + 5].b, 8'h00);
    chk("pin_trail1", exp_q[SYNC_IDX + 6].b, 8'h00);
    chk("pin_exit_lp", {6'd0, exp_q[SYNC_IDX + 7].lp}, 8'd3);
    drive(0, s_byte.size());
    wait_empty();

    s_byte = '{8'h10, 8'h7F};
    s_last = '{1'b0, 1'b1};
    model(0);
    chk("pin_7f_trail0", exp_q[SYNC_IDX + 3].b, 8'hFF);
    chk("pin_7f_trail1", exp_q[SYNC_IDX + 4].b, 8'hFF);
    drive(0, s_byte.size());
    wait_empty();

    s_byte = '{8'h01};
    s_last = '{1'b1};
    model(0);
    chk("pin_one_byte", exp_q[SYNC_IDX + 1].b, 8'h01);
    chk("pin_one_trail", exp_q[SYNC_IDX + 2].b, 8'hFF);
    drive(0, s_byte.size());
    wait_empty();

    s_byte = '{8'hA1, 8'h42, 8'hC3, 8'h24, 8'h95};
    s_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    model(2);
    u = 0;
    foreach (exp_q[i]) if (exp_q[i].uf) u++;
    chk("pin_uf_count", 8'(u), 8'd1);
    chk("pin_uf_trail", exp_q[SYNC_IDX + 3].b, 8'hFF);
    chk("pin_uf_pos", {7'd0, exp_q[SYNC_IDX + 3].uf}, 8'd1);
    drive(2, s_byte.size());
    wait_empty();

    s_byte = '{8'h55, 8'hC3, 8'h3C, 8'h0A};
    s_last = '{1'b0, 1'b1, 1'b0, 1'b1};
    model(0);
    chk("pin_b2b_len", 8'(exp_q.size()), LP_EN ? 8'd34 : 8'd22);
    chk("pin_b2b_idle", {7'd0, exp_q[exp_q.size() / 2].busy}, 8'd0);
    chk("pin_b2b_next", {7'd0, exp_q[exp_q.size() / 2 + 1].busy}, 8'd1);
    drive(0, s_byte.size());
    wait_empty();

    s_byte = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    s_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(0, 2);
    @(negedge clk);
    chk("mid_data_hs", {7'd0, hs_en}, 8'd1);
    chk("mid_data_byte", byte_out, 8'h5B);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_hs", {7'd0, hs_en}, 8'd0);
    chk("rst_lp", {6'd0, lp}, 8'd3);
    chk("rst_byte", byte_out, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_uf", {7'd0, uf}, 8'd0);
    chk("rst_ready", {7'd0, ready}, 8'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    s_byte = '{8'h99, 8'hE6};
    s_last = '{1'b0, 1'b1};
    model(0);
    drive(0, s_byte.size());
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
